mux_equiv_checker: RTL
======================

# mux_equiv_checker

Self-checking equivalence harness that drives two 3:1 multiplexer implementations with identical pseudo-random vectors and compares their outputs. It sits on both sides of the DUT pair: upstream as the stimulus generator for the five select/data inputs, and downstream as the comparator and error reporter. It brings the random-compare-stop flow into synthesizable, cycle-exact RTL.

## Interface
- NUM_VECTORS, 10, vectors applied per run (1..65535)
- SETTLE_CYCLES, 1, cycles between driving a vector and comparing outputs (1..15)
- LFSR_SEED, 16'hACE1, LFSR load value on reset and on each start; must be nonzero
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a run when in IDLE or DONE, ignored otherwise
- d0, d1, d2, s0, s1  out  1 each  stimulus to both DUTs (s1 is the MSB of the select)
- out_a, out_b  in  1 each  outputs of DUT A and DUT B
- busy  out  1  high in DRIVE, SETTLE and CHECK
- done  out  1  high in DONE; held until the next start or reset
- error  out  1  sticky; set on the first mismatch, cleared by start or rst
- vec_count  out  16  vectors compared in the current run
- err_count  out  16  mismatches in the current run, saturating at 16'hFFFF
- err_vector  out  5  {s1,s0,d2,d1,d0} of the first failing vector

## Operation
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE/DONE + start -> DRIVE. Reload the LFSR with LFSR_SEED and clear vec_count, err_count, error and err_vector.
- DRIVE: latch {s1,s0,d2,d1,d0} = lfsr[4:0] into output registers, advance the LFSR once, load the settle counter with SETTLE_CYCLES-1, then go to SETTLE.
- SETTLE: decrement the counter; at 0 go to CHECK.
- CHECK: compare out_a with out_b, then increment vec_count.
  - On mismatch: set error, increment err_count (saturating), and capture err_vector only if error was 0.
  - Next state is DONE if vec_count+1 == NUM_VECTORS, else DRIVE.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It shifts only in DRIVE.
- Stimulus outputs hold their value in SETTLE, CHECK and DONE.
- X/Z on out_a or out_b counts as a mismatch under case-inequality (!==) in simulation. Synthesis uses plain !=.

## Timing
- Reset values:
  - State: IDLE.
  - d0..s1, busy, done, error, vec_count, err_count, err_vector: 0.
  - LFSR: LFSR_SEED.
- Per-vector period is SETTLE_CYCLES+2 clocks. Full run is NUM_VECTORS*(SETTLE_CYCLES+2) clocks from the start edge to done rising.
- busy rises on the clock edge after start is sampled.
- vec_count and err_count update on the CHECK edge. done rises one edge after the final CHECK.
- start while busy is ignored; there is no restart mid-run.
- rst mid-run returns everything to reset values immediately, asynchronously.
- If start and the final CHECK occur in the same cycle, start is ignored because the FSM is still busy.

## Configuration
- MUX_CHK_STOP_ON_ERR_EN defined: a mismatch in CHECK moves the FSM straight to DONE. vec_count then includes the failing vector and err_count = 1.
- Not defined: all NUM_VECTORS vectors always run, and err_count accumulates.

## Structure
- Package mux_chk_pkg holds:
  - the state enum typedef;
  - the VEC_W = 5 constant;
  - the LFSR width and tap-mask constants;
  - a typedef for the packed stimulus vector.
- One sub-module, mux_chk_lfsr: seed load, enable, and parallel state output. The FSM, counters and comparator live in the top module.

## Test plan
- Reset then idle: rst for 3 cycles, no start -> all outputs 0, and busy stays 0 for 20 cycles.
- Clean run: out_a and out_b tied to a correct mux model for both DUTs, start, NUM_VECTORS=10, SETTLE_CYCLES=1 -> done at cycle 30 after start, vec_count=10, err_count=0, error=0, and the vector sequence matches a reference LFSR from 16'hACE1.
- Fault injection: out_b inverted on vector 4 only -> error=1, err_vector equals the 4th LFSR vector. Without the macro: err_count=1, vec_count=10. With MUX_CHK_STOP_ON_ERR_EN: done after vec_count=4.
- Persistent fault: out_b stuck at 0 with the macro undefined -> err_count equals the number of vectors whose correct output is 1, and err_vector holds the first such vector.
- Reset mid-run: rst asserted in SETTLE of vector 5 -> all outputs 0 within the same cycle. A subsequent start reproduces the same first vector as a fresh run.
- Start while busy and restart from DONE: start pulsed at vector 3 -> ignored, run completes normally. start in DONE -> counters and error clear, and the sequence restarts from the seed.

Source files
------------

// File: rtl/mux_chk_pkg.sv
// Shared types and constants for the 3:1 mux equivalence checker.
package mux_chk_pkg;

  localparam int VEC_W  = 5;
  localparam int LFSR_W = 16;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic s1;
    logic s0;
    logic d2;
    logic d1;
    logic d0;
  } stim_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/mux_chk_if.sv
// Stimulus/response bundle between the checker and the pair of mux DUTs.
interface mux_chk_if;
  logic d0;
  logic d1;
  logic d2;
  logic s0;
  logic s1;
  logic out_a;
  logic out_b;

  modport master (output d0, d1, d2, s0, s1, input out_a, out_b);
  modport slave  (input d0, d1, d2, s0, s1, output out_a, out_b);
endinterface

// File: rtl/mux_chk_lfsr.sv
// 16-bit Galois LFSR with synchronous seed load and shift enable.
module mux_chk_lfsr
  import mux_chk_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (en) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/mux_equiv_checker.sv
// Drives two 3:1 muxes with LFSR vectors and compares their outputs.
// Optional MUX_CHK_STOP_ON_ERR_EN: end the run on the first mismatch.
//
// state  | meaning
// IDLE   | waiting for start after reset
// DRIVE  | latch next LFSR vector onto the stimulus outputs
// SETTLE | wait SETTLE_CYCLES for the DUTs to respond
// CHECK  | compare out_a against out_b, update counters
// DONE   | run finished, results held until start or rst
module mux_equiv_checker
  import mux_chk_pkg::*;
#(
  parameter int                NUM_VECTORS   = 10,
  parameter int                SETTLE_CYCLES = 1,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  mux_chk_if.master        mux_bus,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [15:0]      vec_count,
  output logic [15:0]      err_count,
  output logic [VEC_W-1:0] err_vector
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

`ifdef MUX_CHK_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  state_t            state_q;
  state_t            state_d;
  stim_t             stim_q;
  logic [3:0]        settle_cnt;
  logic [LFSR_W-1:0] lfsr_state;
  logic [LFSR_W-VEC_W-1:0] lfsr_unused;
  logic              start_ok;
  logic              mismatch;
  logic              last_vec;

  assign start_ok    = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_vec    = ({1'b0, vec_count} + 17'd1) == 17'(NUM_VECTORS);
  assign lfsr_unused = lfsr_state[LFSR_W-1:VEC_W];

  // X/Z on either DUT output must be flagged in simulation
`ifdef SYNTHESIS
  assign mismatch = (mux_bus.out_a != mux_bus.out_b);
`else
  assign mismatch = (mux_bus.out_a !== mux_bus.out_b);
`endif

  mux_chk_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_ok),
    .en    (state_q == ST_DRIVE),
    .state (lfsr_state)
  );

  assign mux_bus.d0 = stim_q.d0;
  assign mux_bus.d1 = stim_q.d1;
  assign mux_bus.d2 = stim_q.d2;
  assign mux_bus.s0 = stim_q.s0;
  assign mux_bus.s1 = stim_q.s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        busy    = 1'b1;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == 4'd0) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        busy = 1'b1;
        if (last_vec || (STOP_ON_ERR && mismatch)) state_d = ST_DONE;
        else                                       state_d = ST_DRIVE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_d = ST_DRIVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim_q     <= '0;
      settle_cnt <= '0;
      error      <= 1'b0;
      vec_count  <= '0;
      err_count  <= '0;
      err_vector <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            error      <= 1'b0;
            vec_count  <= '0;
            err_count  <= '0;
            err_vector <= '0;
          end
        end
        ST_DRIVE: begin
          stim_q     <= stim_t'(lfsr_state[VEC_W-1:0]);
          settle_cnt <= SETTLE_LOAD;
        end
        ST_SETTLE: begin
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        ST_CHECK: begin
          vec_count <= vec_count + 16'd1;
          if (mismatch) begin
            error <= 1'b1;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (!error) err_vector <= stim_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
